// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls words from an upstream FIFO and sends each as a UART frame (start, LSB-first data, stop).
// Build option UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
   parameter int DATAWIDTH    = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 fifo_empty,
   output logic                 fifo_rd,
   input  logic [DATAWIDTH-1:0] fifo_data,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(DATAWIDTH - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif

   state_t               r_state, w_state_next;
   logic [TW-1:0]        r_timer, w_timer_next;
   logic [BW-1:0]        r_bit_idx, w_bit_idx_next;
   logic [DATAWIDTH-1:0] r_shift, w_shift_next;
   logic                 r_tx, w_tx_next;
   logic                 w_rd;
   logic                 w_timer_end;
   logic [DATAWIDTH-1:0] w_shifted;
`ifdef UART_TX_PARITY_EN
   logic                 r_parity, w_parity_next;
`endif

   assign w_rd        = (r_state == IDLE) && en && !fifo_empty && !rst;
   assign w_timer_end = (r_timer == TIMER_LAST);
   assign w_shifted   = r_shift >> 1;

   assign fifo_rd = w_rd;
   assign tx      = r_tx;
   assign busy    = (r_state != IDLE);
   assign tx_done = (r_state == STOP) && w_timer_end && !rst;

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_next   = r_state;
      w_timer_next   = r_timer;
      w_bit_idx_next = r_bit_idx;
      w_shift_next   = r_shift;
      w_tx_next      = r_tx;
`ifdef UART_TX_PARITY_EN
      w_parity_next  = r_parity;
`endif
      if (r_state != IDLE && r_state != LOAD) begin
         w_timer_next = w_timer_end ? '0 : r_timer + 1'b1;
      end
      unique case (r_state)
         IDLE: begin
            if (w_rd) w_state_next = LOAD;
         end
         LOAD: begin
            w_shift_next = fifo_data;
            w_tx_next    = 1'b0;
            w_state_next = START;
`ifdef UART_TX_PARITY_EN
            w_parity_next = ^fifo_data;
`endif
         end
         START: begin
            if (w_timer_end) begin
               w_tx_next    = r_shift[0];
               w_state_next = DATA;
            end
         end
         DATA: begin
            if (w_timer_end) begin
               w_shift_next = w_shifted;
               if (r_bit_idx == BIT_LAST) begin
                  w_bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                  w_tx_next    = r_parity;
                  w_state_next = PARITY;
`else
                  w_tx_next    = 1'b1;
                  w_state_next = STOP;
`endif
               end else begin
                  w_bit_idx_next = r_bit_idx + 1'b1;
                  w_tx_next      = w_shifted[0];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_timer_end) begin
               w_tx_next    = 1'b1;
               w_state_next = STOP;
            end
         end
`endif
         STOP: begin
            if (w_timer_end) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // A reset mid-frame drops the word in flight and returns the line to idle-high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_timer   <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_next;
         r_timer   <= w_timer_next;
         r_bit_idx <= w_bit_idx_next;
         r_shift   <= w_shift_next;
         r_tx      <= w_tx_next;
`ifdef UART_TX_PARITY_EN
         r_parity  <= w_parity_next;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds words, a frame monitor decodes tx and scores each frame
// against the expected word queued by the stimulus.
module tb_fifo_uart_tx;

   localparam int DW  = 8;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = DW + 3;
`else
   localparam int NB = DW + 2;
`endif
   localparam int FRAME = NB * CPB;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          par;
   } exp_t;

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic          en         = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data  = '0;
   logic          fifo_rd, tx, busy, tx_done;

   logic [DW-1:0] fifo_q[$];
   exp_t          exp_q[$];

   int   checks = 0, failures = 0, cyc = 0;
   int   rd_count = 0, done_count = 0, viol = 0, last_rd_cyc = -100;
   logic prev_rd = 1'b0;
   int   frames_ok = 0, prev_done_cyc = -1, last_gap = -1;

   fifo_uart_tx #(.DATAWIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .fifo_empty(fifo_empty),
      .fifo_rd   (fifo_rd),
      .fifo_data (fifo_data),
      .tx        (tx),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // FIFO model: data appears the cycle after the read strobe, empty updates after the edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd === 1'b1 && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
   end

   always @(negedge clk) begin
      if (fifo_rd === 1'b1) begin
         rd_count++;
         last_rd_cyc = cyc;
         if (fifo_empty || prev_rd || rst) viol++;
      end
      prev_rd = (fifo_rd === 1'b1);
      if (tx_done === 1'b1) done_count++;
   end

   initial begin : frame_mon
      exp_t          fe;
      logic [NB-1:0] ef, gf;
      int            bad, sc, rdc;
      logic          ab;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && tx === 1'b0) begin
            sc = cyc; rdc = last_rd_cyc; bad = 0; ab = 1'b0; gf = '0;
            check("frame_has_word", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) fe = exp_q.pop_front();
            else fe = '0;
            ef = '0;
            for (int i = 0; i < DW; i++) ef[1+i] = fe.data[i];
`ifdef UART_TX_PARITY_EN
            ef[DW+1] = fe.par;
`endif
            ef[NB-1] = 1'b1;
            for (int b = 0; b < NB && !ab; b++) begin
               for (int k = 0; k < CPB && !ab; k++) begin
                  if (!(b == 0 && k == 0)) @(negedge clk);
                  if (rst !== 1'b0) ab = 1'b1;
                  else begin
                     if (tx !== ef[b]) bad++;
                     if (busy !== 1'b1) bad++;
                     if (tx_done !== (b == NB-1 && k == CPB-1)) bad++;
                     if (k == CPB/2) gf[b] = tx;
                  end
               end
            end
            if (!ab) begin
               check($sformatf("frame_bits_%02h", fe.data), gf, ef);
               check($sformatf("frame_timing_%02h", fe.data), bad, 0);
               check("start_latency", sc - rdc, 2);
               check("done_latency", cyc - rdc, FRAME + 1);
               if (prev_done_cyc >= 0) last_gap = sc - prev_done_cyc - 1;
               prev_done_cyc = cyc;
               frames_ok++;
            end else begin
               prev_done_cyc = -1;
            end
         end
      end
   end

   task automatic push_word(input logic [DW-1:0] d, input logic par);
      fifo_q.push_back(d);
      exp_q.push_back('{data: d, par: par});
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      @(negedge clk);
      while ((busy !== 1'b0 || fifo_empty !== 1'b1) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle", n < limit, 1);
   endtask

   task automatic wait_rd(input int limit);
      int n = 0;
      while (fifo_rd !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("wait_rd", n < limit, 1);
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (tx_done !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("wait_done", n < limit, 1);
   endtask

   initial begin : stim
      int rd0, done0, idle_bad;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_rd", fifo_rd, 0);
      check("rst_done", tx_done, 0);
      rst = 1'b0;
      en  = 1'b1;

      // Empty FIFO with enable high: line idles, no reads.
      rd0 = rd_count; idle_bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
      end
      check("empty_no_rd", rd_count - rd0, 0);
      check("empty_idle_line", idle_bad, 0);

      // Single word 0xA5: 0,1,0,1,0,0,1,0,1,1 on the line.
      rd0 = rd_count; done0 = done_count;
      push_word(8'hA5, 1'b0);
      wait_idle(200);
      check("a5_rd_pulses", rd_count - rd0, 1);
      check("a5_done_pulses", done_count - done0, 1);
      check("a5_busy_low", busy, 0);

      // Back-to-back 0x01, 0x80: two idle-high cycles between stop end and next start.
      rd0 = rd_count; done0 = done_count;
      push_word(8'h01, 1'b1);
      push_word(8'h80, 1'b1);
      wait_idle(300);
      check("b2b_rd_pulses", rd_count - rd0, 2);
      check("b2b_done_pulses", done_count - done0, 2);
      check("b2b_gap", last_gap, 2);

      // Enable dropped mid-frame: frame completes, pending word is not fetched.
      push_word(8'h3C, 1'b0);
      wait_rd(50);
      repeat (10) @(negedge clk);
      en = 1'b0;
      push_word(8'h11, 1'b0);
      rd0 = rd_count; done0 = done_count;
      wait_done(100);
      repeat (20) @(negedge clk);
      check("en_off_no_rd", rd_count - rd0, 0);
      check("en_off_done", done_count - done0, 1);
      check("en_off_busy", busy, 0);
      check("en_off_pending", fifo_empty, 0);
      en = 1'b1;
      wait_idle(200);

      // Reset at cycle 15 of a frame: word dropped, no done pulse, next word clean.
      push_word(8'h5A, 1'b0);
      wait_rd(50);
      repeat (15) @(negedge clk);
      done0 = done_count;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_tx", tx, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rd", fifo_rd, 0);
      check("mid_rst_done", tx_done, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_no_done", done_count - done0, 0);
      push_word(8'hC3, 1'b0);
      wait_idle(200);
      check("post_rst_done", done_count - done0, 1);

      // 0x07 has odd weight: parity bit 1 when parity is built in.
      push_word(8'h07, 1'b1);
      wait_idle(200);

      repeat (5) @(negedge clk);
      check("rd_protocol", viol, 0);
      check("done_vs_frames", done_count, frames_ok);
      check("frames_total", frames_ok, 7);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Serial transmit stage that drains the byte FIFO from its read side and shifts each word out as an asynchronous UART frame (start, data LSB-first, stop).
- Sits directly downstream of the FIFO: drives its RD, observes empty, and captures dataOut one cycle after RD.
- Single clock domain. Baud timing is set by a fixed clocks-per-bit divider.

Parameters:
- DATAWIDTH, 8: bits per word; must match the upstream FIFO data width.
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range is 2 or more.

Ports:
- clk, input, 1: system clock; all logic acts on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: transmit enable; when low, no new word is fetched.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_rd, output, 1: FIFO read strobe; one-cycle pulse per word.
- fifo_data, input, DATAWIDTH: FIFO dataOut; valid the cycle after fifo_rd.
- tx, output, 1: serial line; idles high.
- busy, output, 1: high whenever state is not IDLE.
- tx_done, output, 1: one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset state: IDLE, tx=1, busy=0, tx_done=0, fifo_rd=0, all counters 0. Reset has priority over every other event.
- fifo_rd is combinational: (state==IDLE) && en && !fifo_empty && !rst.
  - Never asserted while fifo_empty=1.
  - Never high for two consecutive cycles.
- States and transitions:
  - IDLE: if fifo_rd, go to LOAD.
  - LOAD: one cycle; fifo_data is valid. Latch it into the shift register, set tx<=0, go to START.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then tx<=shift[0] and go to DATA.
  - DATA: each bit lasts CLKS_PER_BIT cycles; at bit end, shift right. After bit DATAWIDTH-1 ends, tx<=1 and go to STOP (or PARITY when the optional feature is compiled in).
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. tx_done=1 in the final cycle, then go to IDLE.
- tx is registered. The first start-bit cycle is 2 clocks after the fifo_rd cycle.
- Frame length is (DATAWIDTH+2)*CLKS_PER_BIT cycles.
- Back-to-back words: after STOP, one IDLE cycle (fifo_rd) plus one LOAD cycle. The line stays high for exactly CLKS_PER_BIT+2 cycles between start bits of consecutive frames' stop/start boundary, i.e. 2 extra idle-high cycles.
- Counters:
  - Bit-timer width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary.
  - Bit index width is $clog2(DATAWIDTH), or 1 minimum. It wraps to 0 on leaving DATA.
- en deasserted mid-frame: the current frame completes normally; no new fetch occurs. en is sampled only in IDLE.
- fifo_empty rising during LOAD or later: no effect on the current frame.
- Reset mid-frame: next cycle tx=1, state IDLE. The partially sent word is dropped; no tx_done pulse.
- busy=1 in LOAD, START, DATA, PARITY and STOP.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of all data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes (DATAWIDTH+3)*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Test Plan (DATAWIDTH=8, CLKS_PER_BIT=4):
- FIFO holds 0xA5, en=1 → one fifo_rd pulse; 2 cycles later tx emits 0,1,0,1,0,0,1,0,1,1 (4 cycles each, 40 total); tx_done at cycle 41 relative to fifo_rd; busy low after.
- FIFO holds 0x01 then 0x80 → exactly 2 fifo_rd pulses. tx bits are 0,1,0000000,1 then 0,0000000,1,1. Exactly 2 idle-high cycles between stop end and next start.
- fifo_empty=1 for 100 cycles with en=1 → fifo_rd never asserted; tx=1, busy=0 throughout.
- Word 0x3C in flight, en dropped at cycle 10 of frame → frame completes and tx_done pulses. No further fifo_rd while en=0, even with fifo_empty=0.
- rst pulsed at cycle 15 of a frame → next cycle tx=1, busy=0, fifo_rd=0, no tx_done. The next word is transmitted cleanly after rst releases.
- UART_TX_PARITY_EN defined: 0xA5 gives parity bit 0 and 0x07 gives parity bit 1. Each frame is 44 cycles.
